friscv_seq_alu: RTL and testbench

- Parametrised, handshaked multi-cycle ALU; the successor to the single-cycle combinational ALU op set.
- Executes the standard op encoding at configurable WIDTH.
- Shifts are iterative, at SHIFT_STEP bit positions per cycle, trading latency for area.
- An optional iterative multiplier is available.
- Sits between the decode/issue stage and writeback; uses valid/ready on both sides so the pipeline can stall on it.

---
 rtl/friscv_seq_alu_if.sv | 26 ++
 rtl/friscv_seq_alu.sv | 155 +++++++++++++++
 tb/tb_friscv_seq_alu.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/friscv_seq_alu_if.sv
// Request/result handshake bundle for friscv_seq_alu: issue side drives the
// operation, the ALU answers with a registered result.
interface friscv_seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, err
  );

  modport slave (
    input  in_valid, op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, err
  );
endinterface

// File: rtl/friscv_seq_alu.sv
// Handshaked multi-cycle ALU with iterative shifter (SHIFT_STEP bits/cycle).
// Optional radix-2 multiplier enabled by defining FRISCV_SEQ_ALU_MUL_EN.
//
// state | meaning
// IDLE  | ready for a request (in_ready=1)
// BUSY  | iterating a shift or multiply
// DONE  | result presented until out_ready
module friscv_seq_alu #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic               clk,
  input logic               rst,
  friscv_seq_alu_if.slave   alu
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SAR = 4'b0111;
  localparam logic [3:0] OP_SLR = 4'b1000;
`ifdef FRISCV_SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1001;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [CW-1:0]    step_k;
  logic [SW-1:0]    shamt;
`ifdef FRISCV_SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

  assign shamt  = alu.op_b[SW-1:0];
  assign step_k = (cnt_q > STEP_C) ? STEP_C : cnt_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    err_d   = err_q;
`ifdef FRISCV_SEQ_ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    case (state_q)
      IDLE: begin
        if (alu.in_valid) begin
          op_d    = alu.op;
          err_d   = 1'b0;
          state_d = DONE;
          case (alu.op)
            OP_AND: acc_d = alu.op_a & alu.op_b;
            OP_OR:  acc_d = alu.op_a | alu.op_b;
            OP_XOR: acc_d = alu.op_a ^ alu.op_b;
            OP_ADD: acc_d = alu.op_a + alu.op_b;
            OP_SUB: acc_d = alu.op_a - alu.op_b;
            OP_SLT: acc_d = ($signed(alu.op_a) < $signed(alu.op_b)) ? WIDTH'(1) : '0;
            OP_SLL, OP_SAR, OP_SLR: begin
              acc_d = alu.op_a;
              cnt_d = {1'b0, shamt};
              if (shamt != '0) state_d = BUSY;
            end
`ifdef FRISCV_SEQ_ALU_MUL_EN
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = alu.op_a;
              mplier_d = alu.op_b;
              cnt_d    = CW'(WIDTH);
              state_d  = BUSY;
            end
`endif
            default: begin
              acc_d = '0;
              err_d = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
`ifdef FRISCV_SEQ_ALU_MUL_EN
        if (op_q == OP_MUL) begin
          acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
        end else
`endif
        begin
          case (op_q)
            OP_SLL:  acc_d = acc_q << step_k;
            OP_SAR:  acc_d = $signed(acc_q) >>> step_k;
            default: acc_d = acc_q >> step_k;
          endcase
          cnt_d = cnt_q - step_k;
        end
        if (cnt_d == '0) state_d = DONE;
      end
      DONE: begin
        if (alu.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // zero is latched once on entry to DONE so it stays stable with the result
    if (state_d == DONE && state_q != DONE) zero_d = (acc_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef FRISCV_SEQ_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifdef FRISCV_SEQ_ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign alu.in_ready  = (state_q == IDLE);
  assign alu.out_valid = (state_q == DONE);
  assign alu.result    = acc_q;
  assign alu.zero      = zero_q;
  assign alu.err       = err_q;
endmodule

// File: tb/tb_friscv_seq_alu.sv
// Self-checking bench for friscv_seq_alu (WIDTH=32, SHIFT_STEP=4): directed
// cases plus random ops against an arithmetic reference model.
module tb_friscv_seq_alu;
  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SW    = $clog2(WIDTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  friscv_seq_alu_if #(.WIDTH(WIDTH)) bus ();
  friscv_seq_alu #(.WIDTH(WIDTH), .SHIFT_STEP(STEP)) dut (.clk(clk), .rst(rst), .alu(bus));

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // {err, result}
  function automatic logic [WIDTH:0] ref_alu(input logic [3:0] op, input logic [WIDTH-1:0] a, b);
    int sh;
    sh = int'(b[SW-1:0]);
    case (op)
      4'd0: return {1'b0, a & b};
      4'd1: return {1'b0, a | b};
      4'd2: return {1'b0, a ^ b};
      4'd3: return {1'b0, a + b};
      4'd4: return {1'b0, a - b};
      4'd5: return {1'b0, ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0)};
      4'd6: return {1'b0, a << sh};
      4'd7: return {1'b0, WIDTH'($signed(a) >>> sh)};
      4'd8: return {1'b0, a >> sh};
`ifdef FRISCV_SEQ_ALU_MUL_EN
      4'd9: return {1'b0, a * b};
`endif
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [WIDTH-1:0] b);
    int sh;
    sh = int'(b[SW-1:0]);
    if (op >= 4'd6 && op <= 4'd8) return (sh == 0) ? 1 : (sh + STEP - 1) / STEP + 1;
`ifdef FRISCV_SEQ_ALU_MUL_EN
    if (op == 4'd9) return WIDTH + 1;
`endif
    return 1;
  endfunction

  task automatic do_op(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a, b,
                       input int stall, output logic [WIDTH-1:0] got, output logic got_zero);
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] held;
    int               lat, n;
    bit               busy_bad, stall_bad;
    exp = ref_alu(op, a, b);
    lat = ref_lat(op, b);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
    n = 1; busy_bad = 0;
    while (!bus.out_valid && n < 200) begin
      if (bus.in_ready) busy_bad = 1;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_busy_in_ready"}, 64'(busy_bad), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'(exp[WIDTH-1:0]));
    check({tag, "_err"}, 64'(bus.err), 64'(exp[WIDTH]));
    check({tag, "_zero"}, 64'(bus.zero), 64'(exp[WIDTH-1:0] == '0));
    got = bus.result; got_zero = bus.zero;
    held = bus.result; stall_bad = 0;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1; bus.op = 4'($urandom); bus.op_a = $urandom;
      @(negedge clk);
      if (!bus.out_valid || bus.result !== held || bus.in_ready) stall_bad = 1;
    end
    bus.in_valid = 1'b0;
    if (stall > 0) check({tag, "_stall_hold"}, 64'(stall_bad), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_post_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] r;
    logic             z;
    logic [3:0]       rop;
    logic [WIDTH-1:0] ra, rb;
    int               seen;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = '0; bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;

    do_op("add_wrap", 4'd3, 32'hFFFFFFFF, 32'h1, 0, r, z);
    check("add_wrap_const", 64'(r), 64'h0);
    check("add_wrap_zero_const", 64'(z), 64'd1);
    do_op("slt_neg", 4'd5, 32'hFFFFFFFF, 32'h1, 0, r, z);
    check("slt_neg_const", 64'(r), 64'h1);
    do_op("slt_swap", 4'd5, 32'h1, 32'hFFFFFFFF, 0, r, z);
    check("slt_swap_const", 64'(r), 64'h0);
    do_op("sar7", 4'd7, 32'h80000000, 32'd7, 0, r, z);
    check("sar7_const", 64'(r), 64'hFF000000);
    do_op("slr7", 4'd8, 32'h80000000, 32'd7, 0, r, z);
    check("slr7_const", 64'(r), 64'h01000000);
    do_op("bp_add", 4'd3, 32'd5, 32'd3, 5, r, z);
    check("bp_add_const", 64'(r), 64'h8);
    do_op("illegal", 4'b1111, 32'h1234, 32'h5678, 1, r, z);
    check("illegal_const", 64'(r), 64'h0);
`ifdef FRISCV_SEQ_ALU_MUL_EN
    do_op("mul_neg", 4'd9, 32'd7, 32'hFFFFFFFD, 0, r, z);
    check("mul_neg_const", 64'(r), 64'hFFFFFFEB);
    do_op("mul_ovf", 4'd9, 32'h10000, 32'h10000, 0, r, z);
    check("mul_ovf_zero_const", 64'(z), 64'd1);
`else
    do_op("mul_off", 4'd9, 32'd7, 32'd3, 0, r, z);
    check("mul_off_const", 64'(r), 64'h0);
`endif

    // reset in the middle of a long shift discards the pending result
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd6; bus.op_a = $urandom; bus.op_b = 32'd31;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midrst_no_stale", 64'(seen), 64'd0);

    for (int k = 0; k < 40; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (k % 5 == 0) rb[SW-1:0] = '0;
      if (k % 7 == 0) ra = '0;
      do_op($sformatf("rnd%0d_op%0d", k, rop), rop, ra, rb, $urandom_range(0, 3), r, z);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
